mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file.
- It consumes Read_Data_1 (rs) and Read_Data_2 (rt) as operands and holds the architectural HI/LO pair.
- It serves MULT, MULTU, DIV and DIVU, and HI/LO moves (mthi/mtlo writes, mfhi/mflo reads via Hi/Lo).
- The control unit stalls on Busy. mfhi/mflo results return to the register file's Write_Data path.

Parameters:
- WIDTH, 32, operand width; Hi and Lo are each WIDTH bits.

Ports:
- Clock  input  1  single clock; all state changes on posedge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request a new operation; sampled on posedge.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- Operand_A  input  WIDTH  rs value (multiplicand / dividend).
- Operand_B  input  WIDTH  rt value (multiplier / divisor).
- Hi_Write  input  1  mthi strobe.
- Lo_Write  input  1  mtlo strobe.
- Write_Data  input  WIDTH  data for mthi/mtlo.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle completion pulse.
- Div_By_Zero  output  1  valid while Done=1; set for DIV/DIVU with Operand_B=0.
- Hi  output  WIDTH  HI register (product high half / remainder).
- Lo  output  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset (Reset_n=0, any time, asynchronous):
  - Hi=0, Lo=0, Busy=0, Done=0, Div_By_Zero=0.
  - FSM returns to IDLE and the iteration counter clears.
  - An in-flight operation is discarded; no Done is produced for it.
- FSM states:
  - IDLE: Busy=0.
  - RUN: Busy=1; WIDTH iteration edges.
  - FIX: Busy=1; one sign-fixup/commit edge.
- Transitions:
  - IDLE->RUN on an edge with Start=1.
  - RUN->FIX when the counter reaches WIDTH-1.
  - FIX->IDLE always.
- Accept edge E0:
  - Latch Op, the absolute values of the operands (signed ops), the result-sign flags, and the divide-by-zero flag.
  - Busy=1 after E0.
- RUN, edges E1..E_WIDTH, one bit per edge:
  - Multiply: shift-add producing a 2*WIDTH-bit unsigned product.
  - Divide: restoring division producing an unsigned quotient and remainder.
- FIX, edge E_WIDTH+1:
  - Apply signs and write Hi/Lo.
  - Done=1 and Busy=0 after this edge; Done clears on the next edge.
  - Total latency: WIDTH+1 edges after accept (33 for WIDTH=32).
  - Hi/Lo keep their old values until the commit edge.
- Sign rules:
  - MULT: the product is negated iff the operand signs differ.
  - DIV: the quotient is negated iff the operand signs differ; the remainder takes the dividend's sign.
  - Truncation is toward zero.
- Overflow: DIV of -2^(WIDTH-1) by -1 gives Lo=0x80000000, Hi=0 (wraps; no flag).
- Divide by zero (DIV or DIVU with Operand_B=0):
  - Normal latency.
  - Lo=all ones, Hi=Operand_A as latched (raw, not sign-processed).
  - Div_By_Zero=1 in the Done cycle; otherwise 0.
- Start while Busy=1: ignored, with no queuing. Start in the cycle Done=1 (FSM in IDLE) is accepted.
- Hi_Write / Lo_Write:
  - Applied at the edge only when the FSM is IDLE; ignored while Busy=1.
  - Hi_Write and Lo_Write together update both.
  - A move coinciding with Start in IDLE takes effect; the operation later overwrites Hi/Lo at commit.
- Operand_A/Operand_B/Op may change freely after E0 without effect.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Busy high for 33 cycles, then Done pulse; Hi=0xFFFFFFFE, Lo=0x00000001, Div_By_Zero=0.
- MULT 0xFFFFFFFD (-3) x 0x00000005 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 7 / 2 -> Lo=3, Hi=1.
- DIVU 0x00000007 / 0 -> Lo=0xFFFFFFFF, Hi=0x00000007, Div_By_Zero=1 for exactly the Done cycle.
- Start MULTU 2x3, then pulse Start (Op DIVU) and Hi_Write (Write_Data=0xDEADBEEF) at cycle 5 -> both ignored; Hi=0, Lo=6. Next, Lo_Write 0x12345678 in IDLE -> Lo=0x12345678 next edge.
- Start DIVU 100/7, drop Reset_n at cycle 10 -> immediately Busy=0, Hi=Lo=0, no Done ever. After release, DIVU 100/7 -> Lo=14, Hi=2 at 33 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply (shift-add) / divide (restoring) unit holding MIPS HI/LO.
// Latency: WIDTH+1 edges from the accept edge to the Done pulse, with Hi/Lo committed on that same edge.
// Backpressure: Busy is high while an operation runs; Start and mthi/mtlo are ignored, not queued, while Busy=1.
//
// Ports:
//   Clock, Reset_n           - clock; asynchronous active-low reset
//   Start, Op[1:0]           - request: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   Operand_A, Operand_B     - rs / rt values, sampled only on the accept edge
//   Hi_Write, Lo_Write,
//   Write_Data               - mthi / mtlo, applied only while idle
//   Busy, Done, Div_By_Zero  - status; Div_By_Zero is qualified by Done
//   Hi, Lo                   - architectural HI/LO registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic             Hi_Write,
    input  logic             Lo_Write,
    input  logic [WIDTH-1:0] Write_Data,
    output logic             Busy,
    output logic             Done,
    output logic             Div_By_Zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_hi_acc;   // multiply: product high half / divide: partial remainder
    logic [WIDTH-1:0] r_lo_acc;   // multiply: multiplier shifting out / divide: dividend -> quotient
    logic [WIDTH-1:0] r_b;        // magnitude of multiplicand or divisor
    logic [WIDTH-1:0] r_raw_a;    // untouched Operand_A, returned in Hi on divide by zero
    logic             r_neg_q;    // negate product / quotient at commit
    logic             r_neg_r;    // negate remainder at commit (dividend was negative)
    logic             r_dbz;
    logic             r_done;
    logic             r_dbz_out;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Signed ops are the ones with Op[0]=0; unsigned ops never see a sign.
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;

    assign w_a_neg = ~Op[0] & Operand_A[WIDTH-1];
    assign w_b_neg = ~Op[0] & Operand_B[WIDTH-1];
    // -(-2^(WIDTH-1)) stays 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_a_abs = w_a_neg ? -Operand_A : Operand_A;
    assign w_b_abs = w_b_neg ? -Operand_B : Operand_B;

    // Shift-add step: add multiplicand when the multiplier LSB is set, then
    // shift the whole {carry, hi, lo} right by one.
    logic [WIDTH:0]   w_mul_sum;
    assign w_mul_sum = {1'b0, r_hi_acc} + (r_lo_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // Restoring step: the remainder is always below the divisor, so the
    // shifted value fits WIDTH+1 bits and the sign of the difference is the
    // "does it fit" decision.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    assign w_shift = {r_hi_acc, r_lo_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
    assign w_fits  = ~w_diff[WIDTH];

    // Commit-time sign application.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    assign w_prod   = {r_hi_acc, r_lo_acc};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -r_lo_acc : r_lo_acc;
    assign w_rem    = r_neg_r ? -r_hi_acc : r_hi_acc;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_hi_acc  <= '0;
            r_lo_acc  <= '0;
            r_b       <= '0;
            r_raw_a   <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Hi_Write) r_hi <= Write_Data;
                    if (Lo_Write) r_lo <= Write_Data;
                    if (Start) begin
                        r_is_div <= Op[1];
                        r_hi_acc <= '0;
                        r_lo_acc <= w_a_abs;
                        r_b      <= w_b_abs;
                        r_raw_a  <= Operand_A;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dbz    <= Op[1] & (Operand_B == '0);
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_hi_acc <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_lo_acc <= {r_lo_acc[WIDTH-2:0], w_fits};
                    end else begin
                        r_hi_acc <= w_mul_sum[WIDTH:1];
                        r_lo_acc <= {w_mul_sum[0], r_lo_acc[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        if (r_dbz) begin
                            r_lo <= '1;
                            r_hi <= r_raw_a;
                        end else begin
                            r_lo <= w_quo;
                            r_hi <= w_rem;
                        end
                    end else begin
                        {r_hi, r_lo} <= w_prod_s;
                    end
                    r_done    <= 1'b1;
                    r_dbz_out <= r_dbz;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy        = (r_state != S_IDLE);
    assign Done        = r_done;
    assign Div_By_Zero = r_dbz_out;
    assign Hi          = r_hi;
    assign Lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboarded bench for mult_div_unit: directed cases plus randomized operations.
// Expected HI/LO come from plain 64-bit arithmetic and are queued at accept.
// A negedge monitor pops and compares on every Done pulse.
module tb_mult_div_unit;

    logic        Clock;
    logic        Reset_n;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] Operand_A;
    logic [31:0] Operand_B;
    logic        Hi_Write;
    logic        Lo_Write;
    logic [31:0] Write_Data;
    logic        Busy;
    logic        Done;
    logic        Div_By_Zero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .Op          (Op),
        .Operand_A   (Operand_A),
        .Operand_B   (Operand_B),
        .Hi_Write    (Hi_Write),
        .Lo_Write    (Lo_Write),
        .Write_Data  (Write_Data),
        .Busy        (Busy),
        .Done        (Done),
        .Div_By_Zero (Div_By_Zero),
        .Hi          (Hi),
        .Lo          (Lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: architectural MIPS semantics with 64-bit arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t           e;
        longint         sp;
        longint         sq;
        longint         sr;
        longint unsigned up;
        e.dbz = 1'b0;
        e.acc = 0;
        e.hi  = '0;
        e.lo  = '0;
        case (op)
            2'b00: begin
                sp   = longint'($signed(a)) * longint'($signed(b));
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            2'b01: begin
                up   = {32'b0, a} * {32'b0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.dbz = 1'b1;
                    e.lo  = 32'hFFFF_FFFF;
                    e.hi  = a;
                end else if (op == 2'b10) begin
                    sq   = longint'($signed(a)) / longint'($signed(b));
                    sr   = longint'($signed(a)) % longint'($signed(b));
                    e.lo = sq[31:0];
                    e.hi = sr[31:0];
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Called between edges with the DUT idle; returns 1 ns after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        Op        = op;
        Operand_A = a;
        Operand_B = b;
        Start     = 1'b1;
        @(posedge Clock);
        #1;
        Start     = 1'b0;
        Op        = 2'($urandom);
        Operand_A = $urandom;
        Operand_B = $urandom;
        e         = model(op, a, b);
        e.acc     = cyc;
        q.push_back(e);
    endtask

    // Leaves the caller at the negedge of the Done cycle (FSM already idle).
    task automatic wait_done(output int busy_cycles);
        bit seen;
        seen        = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge Clock);
            if (Done) seen = 1'b1;
            else if (Busy) busy_cycles++;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_dir(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int bc;
        issue(op, a, b);
        wait_done(bc);
        chk({name, "_hi"}, Hi, ehi);
        chk({name, "_lo"}, Lo, elo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every Done pops one expectation; Div_By_Zero must be 0 outside Done.
    always @(negedge Clock) begin
        exp_t e;
        if (Reset_n) begin
            if (Done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("sb_hi", Hi, e.hi);
                    chk("sb_lo", Lo, e.lo);
                    chk("sb_dbz", Div_By_Zero, e.dbz);
                    chk("sb_latency", 64'(cyc - e.acc), 64'd33);
                    chk("sb_busy_at_done", Busy, 1'b0);
                end
            end else begin
                chk("dbz_outside_done", Div_By_Zero, 1'b0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int dc;
        Reset_n    = 1'b0;
        Start      = 1'b0;
        Op         = 2'b00;
        Operand_A  = '0;
        Operand_B  = '0;
        Hi_Write   = 1'b0;
        Lo_Write   = 1'b0;
        Write_Data = '0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_dbz", Div_By_Zero, 1'b0);
        chk("rst_hi", Hi, 32'h0);
        chk("rst_lo", Lo, 32'h0);
        Reset_n = 1'b1;
        @(negedge Clock);

        // MULTU max x max, with Busy duration.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc);
        chk("multu_busy_cycles", 64'(bc), 64'd33);
        chk("multu_hi", Hi, 32'hFFFF_FFFE);
        chk("multu_lo", Lo, 32'h0000_0001);

        run_dir("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_dir("div_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_dir("div_neg",  2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_dir("divu_7_2", 2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
        run_dir("divu_dbz", 2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        chk("divu_dbz_flag", Div_By_Zero, 1'b1);

        // Start and mthi while busy are both ignored.
        issue(2'b01, 32'd2, 32'd3);
        repeat (4) @(posedge Clock);
        #1;
        Start      = 1'b1;
        Op         = 2'b11;
        Hi_Write   = 1'b1;
        Write_Data = 32'hDEAD_BEEF;
        @(posedge Clock);
        #1;
        Start    = 1'b0;
        Hi_Write = 1'b0;
        wait_done(bc);
        chk("ign_hi", Hi, 32'h0);
        chk("ign_lo", Lo, 32'd6);

        // mtlo while idle, then Hi/Lo held until the next commit.
        Lo_Write   = 1'b1;
        Write_Data = 32'h1234_5678;
        @(posedge Clock);
        #1;
        Lo_Write = 1'b0;
        chk("mtlo_lo", Lo, 32'h1234_5678);
        chk("mtlo_hi_kept", Hi, 32'h0);
        @(negedge Clock);
        issue(2'b01, 32'd2, 32'd3);
        repeat (10) @(posedge Clock);
        #1;
        chk("held_lo_midop", Lo, 32'h1234_5678);
        wait_done(bc);

        // Randomized operations; each next one starts in the Done cycle.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                Hi_Write   = 1'($urandom);
                Lo_Write   = 1'($urandom);
                Write_Data = $urandom;
            end
            issue(2'($urandom), pick(), pick());
            Hi_Write = 1'b0;
            Lo_Write = 1'b0;
            wait_done(bc);
        end
        @(negedge Clock);

        // Asynchronous reset in the middle of an operation.
        issue(2'b11, 32'd100, 32'd7);
        repeat (9) @(posedge Clock);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("arst_busy", Busy, 1'b0);
        chk("arst_hi", Hi, 32'h0);
        chk("arst_lo", Lo, 32'h0);
        chk("arst_done", Done, 1'b0);
        q.delete();
        dc = done_cnt;
        repeat (3) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        repeat (40) @(posedge Clock);
        #1;
        chk("arst_no_done", 64'(done_cnt), 64'(dc));
        chk("arst_idle", Busy, 1'b0);
        run_dir("divu_after_rst", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        repeat (3) @(negedge Clock);
        chk("sb_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
